// File: rtl/pe_param_if.sv
// pe_param_if: ready/valid bundle between a pe_param and the GLB/NoC.
// The array side uses the master modport, the PE uses the slave modport.
interface pe_param_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] ifmap;
    logic [DATA_W-1:0] filter;
    logic [DATA_W-1:0] ipsum;
    logic [DATA_W-1:0] opsum;
    logic              ifmap_valid;
    logic              ifmap_ready;
    logic              filter_valid;
    logic              filter_ready;
    logic              ipsum_valid;
    logic              ipsum_ready;
    logic              opsum_valid;
    logic              opsum_ready;

    modport master (
        output ifmap, ifmap_valid, filter, filter_valid, ipsum, ipsum_valid, opsum_ready,
        input  ifmap_ready, filter_ready, ipsum_ready, opsum, opsum_valid
    );

    modport slave (
        input  ifmap, ifmap_valid, filter, filter_valid, ipsum, ipsum_valid, opsum_ready,
        output ifmap_ready, filter_ready, ipsum_ready, opsum, opsum_valid
    );
endinterface

// File: rtl/pe_param.sv
// pe_param: parametrised row-stationary PE (stride 1/2, standard or depthwise conv).
// Build macro PE_SATURATE_EN: saturating accumulation in CONV instead of wrap-around.
module pe_param #(
    parameter int ELEM_W       = 8,
    parameter int LANES        = 4,
    parameter int DATA_W       = 32,
    parameter int PSUM_W       = 32,
    parameter int IFMAP_DEPTH  = 20,
    parameter int FILTER_DEPTH = 64,
    parameter int PSUM_DEPTH   = 4,
    parameter int CONFIG_W     = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                PE_en,
    input  logic [CONFIG_W-1:0] i_config,
    pe_param_if.slave           bus
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_FILT  = 3'd1,
        RD_IFMAP = 3'd2,
        RD_IPSUM = 3'd3,
        CONV     = 3'd4,
        WR_OPSUM = 3'd5
    } state_e;

    state_e                    state_q, state_d;
    logic [CONFIG_W-1:0]       cfg_q, cfg_d;
    logic [7:0]                ptr_q, ptr_d;
    logic [4:0]                col_q, col_d;
    logic [4:0]                k_q, k_d;
    logic [2:0]                idx_q, idx_d;
    logic [2:0]                f_q, f_d;
    logic [2:0]                m_q, m_d;
    logic [1:0]                beat_q, beat_d;
    logic signed [ELEM_W-1:0]  filt_q [FILTER_DEPTH];
    logic signed [ELEM_W-1:0]  filt_d [FILTER_DEPTH];
    logic signed [ELEM_W-1:0]  ifm_q  [IFMAP_DEPTH];
    logic signed [ELEM_W-1:0]  ifm_d  [IFMAP_DEPTH];
    logic signed [PSUM_W-1:0]  psum_q [PSUM_DEPTH];
    logic signed [PSUM_W-1:0]  psum_d [PSUM_DEPTH];
    logic [DATA_W-1:0]         opsum_q, opsum_d;

    logic                      dw_s;
    int                        p_s, q_s, s_s, n_s, k_s, nf_s, sq_s;
    int                        faddr_s, pidx_s;
    logic signed [ELEM_W-1:0]  fv_s, iv_s;
    logic signed [PSUM_W-1:0]  pval_s, mac_sum_s;
    logic signed [2*ELEM_W-1:0] prod_s;
    logic                      cfg_unused_s;

    function automatic logic signed [PSUM_W-1:0] acc_add(
        input logic signed [PSUM_W-1:0] a,
        input logic signed [PSUM_W-1:0] b
    );
`ifdef PE_SATURATE_EN
        logic signed [PSUM_W:0] wide;
        wide = {a[PSUM_W-1], a} + {b[PSUM_W-1], b};
        if (wide[PSUM_W] != wide[PSUM_W-1]) begin
            acc_add = wide[PSUM_W] ? {1'b1, {(PSUM_W-1){1'b0}}} : {1'b0, {(PSUM_W-1){1'b1}}};
        end else begin
            acc_add = wide[PSUM_W-1:0];
        end
`else
        acc_add = a + b;
`endif
    endfunction

    assign cfg_unused_s = cfg_q[9];

    // Derived loop bounds from the latched configuration.
    always_comb begin
        dw_s = cfg_q[12];
        p_s  = int'(cfg_q[8:7]) + 1;
        q_s  = int'(cfg_q[1:0]) + 1;
        s_s  = cfg_q[13] ? 2 : 1;
        n_s  = dw_s ? q_s : p_s;
        k_s  = q_s * (int'(cfg_q[11:10]) + 1);
        nf_s = dw_s ? 1 : p_s;
        sq_s = s_s * q_s;
    end

    // Operand fetch and accumulate for the current MAC step.
    always_comb begin
        faddr_s = dw_s ? int'(k_q) : int'(f_q) * k_s + int'(k_q);
        pidx_s  = dw_s ? int'(m_q) : int'(f_q);
        fv_s    = {ELEM_W{1'b0}};
        iv_s    = {ELEM_W{1'b0}};
        pval_s  = {PSUM_W{1'b0}};
        for (int e = 0; e < FILTER_DEPTH; e++) fv_s = (e == faddr_s) ? filt_q[e] : fv_s;
        for (int e = 0; e < IFMAP_DEPTH; e++) iv_s = (e == int'(k_q)) ? ifm_q[e] : iv_s;
        for (int e = 0; e < PSUM_DEPTH; e++) pval_s = (e == pidx_s) ? psum_q[e] : pval_s;
        prod_s    = fv_s * iv_s;
        mac_sum_s = acc_add(pval_s, PSUM_W'(prod_s));
    end

    // Next-state, counter, scratchpad and output computation.
    always_comb begin
        int   ptr_n;
        logic done_v;
        state_d = state_q;
        cfg_d   = cfg_q;
        ptr_d   = ptr_q;
        col_d   = col_q;
        k_d     = k_q;
        idx_d   = idx_q;
        f_d     = f_q;
        m_d     = m_q;
        beat_d  = beat_q;
        filt_d  = filt_q;
        ifm_d   = ifm_q;
        psum_d  = psum_q;
        opsum_d = {DATA_W{1'b0}};
        ptr_n   = int'(ptr_q) + q_s;
        done_v  = 1'b0;
        case (state_q)
            IDLE: begin
                if (PE_en) begin
                    cfg_d   = i_config;
                    ptr_d   = 8'd0;
                    col_d   = 5'd0;
                    idx_d   = 3'd0;
                    state_d = RD_FILT;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_FILT: begin
                if (bus.filter_valid) begin
                    for (int e = 0; e < FILTER_DEPTH; e++)
                        for (int j = 0; j < LANES; j++)
                            filt_d[e] = (e == int'(ptr_q) + j) ? bus.filter[j*ELEM_W +: ELEM_W] : filt_d[e];
                    if (ptr_n >= nf_s * k_s) begin
                        ptr_d   = 8'd0;
                        beat_d  = 2'd0;
                        state_d = RD_IFMAP;
                    end else begin
                        ptr_d = 8'(ptr_n);
                    end
                end else begin
                    state_d = RD_FILT;
                end
            end
            RD_IFMAP: begin
                if (bus.ifmap_valid) begin
                    // Stored signed: flipping the MSB maps unsigned activations to two's complement.
                    for (int e = 0; e < IFMAP_DEPTH; e++)
                        for (int j = 0; j < LANES; j++)
                            ifm_d[e] = (e == int'(ptr_q) + j)
                                     ? (bus.ifmap[j*ELEM_W +: ELEM_W] ^ {1'b1, {(ELEM_W-1){1'b0}}})
                                     : ifm_d[e];
                    ptr_d  = 8'(ptr_n);
                    beat_d = beat_q + 2'd1;
                    done_v = (col_q == 5'd0) ? (ptr_n >= k_s) : (int'(beat_q) >= s_s - 1);
                    if (done_v) begin
                        idx_d   = 3'd0;
                        state_d = RD_IPSUM;
                    end else begin
                        state_d = RD_IFMAP;
                    end
                end else begin
                    state_d = RD_IFMAP;
                end
            end
            RD_IPSUM: begin
                if (bus.ipsum_valid) begin
                    for (int e = 0; e < PSUM_DEPTH; e++)
                        psum_d[e] = (e == int'(idx_q)) ? bus.ipsum[PSUM_W-1:0] : psum_d[e];
                    if (int'(idx_q) == n_s - 1) begin
                        idx_d   = 3'd0;
                        k_d     = 5'd0;
                        f_d     = 3'd0;
                        m_d     = 3'd0;
                        state_d = CONV;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    state_d = RD_IPSUM;
                end
            end
            CONV: begin
                for (int e = 0; e < PSUM_DEPTH; e++)
                    psum_d[e] = (e == pidx_s) ? mac_sum_s : psum_d[e];
                m_d = (int'(m_q) + 1 >= q_s) ? 3'd0 : m_q + 3'd1;
                if (int'(k_q) == k_s - 1) begin
                    k_d = 5'd0;
                    if (dw_s || (int'(f_q) == p_s - 1)) begin
                        idx_d   = 3'd0;
                        state_d = WR_OPSUM;
                    end else begin
                        f_d = f_q + 3'd1;
                    end
                end else begin
                    k_d = k_q + 5'd1;
                end
            end
            WR_OPSUM: begin
                if (bus.opsum_ready) begin
                    if (int'(idx_q) == n_s - 1) begin
                        idx_d = 3'd0;
                        if (col_q == cfg_q[6:2]) begin
                            state_d = IDLE;
                        end else begin
                            // Slide the ifmap window by one output column.
                            for (int e = 0; e < IFMAP_DEPTH; e++) begin
                                ifm_d[e] = {ELEM_W{1'b0}};
                                for (int s = 0; s < IFMAP_DEPTH; s++)
                                    ifm_d[e] = (s == e + sq_s) ? ifm_q[s] : ifm_d[e];
                            end
                            ptr_d   = (int'(ptr_q) >= sq_s) ? 8'(int'(ptr_q) - sq_s) : 8'd0;
                            col_d   = col_q + 5'd1;
                            beat_d  = 2'd0;
                            state_d = RD_IFMAP;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    state_d = WR_OPSUM;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        for (int e = 0; e < PSUM_DEPTH; e++)
            opsum_d = ((state_d == WR_OPSUM) && (e == int'(idx_d))) ? DATA_W'($signed(psum_d[e])) : opsum_d;
    end

    // State, counter and scratchpad registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cfg_q   <= {CONFIG_W{1'b0}};
            ptr_q   <= 8'd0;
            col_q   <= 5'd0;
            k_q     <= 5'd0;
            idx_q   <= 3'd0;
            f_q     <= 3'd0;
            m_q     <= 3'd0;
            beat_q  <= 2'd0;
            opsum_q <= {DATA_W{1'b0}};
            for (int e = 0; e < FILTER_DEPTH; e++) filt_q[e] <= {ELEM_W{1'b0}};
            for (int e = 0; e < IFMAP_DEPTH; e++) ifm_q[e] <= {ELEM_W{1'b0}};
            for (int e = 0; e < PSUM_DEPTH; e++) psum_q[e] <= {PSUM_W{1'b0}};
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            ptr_q   <= ptr_d;
            col_q   <= col_d;
            k_q     <= k_d;
            idx_q   <= idx_d;
            f_q     <= f_d;
            m_q     <= m_d;
            beat_q  <= beat_d;
            opsum_q <= opsum_d;
            filt_q  <= filt_d;
            ifm_q   <= ifm_d;
            psum_q  <= psum_d;
        end
    end

    assign bus.filter_ready = (state_q == RD_FILT);
    assign bus.ifmap_ready  = (state_q == RD_IFMAP);
    assign bus.ipsum_ready  = (state_q == RD_IPSUM);
    assign bus.opsum_valid  = (state_q == WR_OPSUM);
    assign bus.opsum        = opsum_q;
endmodule

// File: tb/tb_pe_param.sv
// tb_pe_param: directed, table-driven bench for pe_param with hand-computed opsums.
// Expected overflow values follow PE_SATURATE_EN when the bench is built with it.
module tb_pe_param;
    logic        clk = 1'b0;
    logic        rst;
    logic        PE_en;
    logic [13:0] i_config;
    int          n_tests = 0;
    int          n_fail  = 0;

    pe_param_if #(.DATA_W(32)) bus ();

    pe_param dut (
        .clk      (clk),
        .rst      (rst),
        .PE_en    (PE_en),
        .i_config (i_config),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  fb;
        logic [7:0]  ib;
        logic [31:0] ip;
        logic [31:0] exp_wrap;
        logic [31:0] exp_sat;
    } mac_vec_t;

    mac_vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [13:0] mk_cfg(input logic s2, input logic dw, input int r,
                                           input int p, input int f, input int q);
        logic [1:0] rr, pp, qq;
        logic [4:0] ff;
        rr = 2'(r - 1);
        pp = 2'(p - 1);
        qq = 2'(q - 1);
        ff = 5'(f);
        return {s2, dw, rr, 1'b0, pp, ff, qq};
    endfunction

    function automatic logic [31:0] ifw(input logic [7:0] b);
        return {8'h80, 8'h80, 8'h80, b};
    endfunction

    function automatic logic rdy(input int kind);
        case (kind)
            0:       return bus.filter_ready;
            1:       return bus.ifmap_ready;
            default: return bus.ipsum_ready;
        endcase
    endfunction

    task automatic start(input logic [13:0] cfg);
        PE_en    = 1'b1;
        i_config = cfg;
        @(negedge clk);
        PE_en    = 1'b0;
        i_config = 14'h3FFF;
    endtask

    // kind: 0 filter, 1 ifmap, 2 ipsum; called and returning on a negedge.
    task automatic push(input int kind, input logic [31:0] d);
        int t;
        t = 0;
        case (kind)
            0:       begin bus.filter = d; bus.filter_valid = 1'b1; end
            1:       begin bus.ifmap  = d; bus.ifmap_valid  = 1'b1; end
            default: begin bus.ipsum  = d; bus.ipsum_valid  = 1'b1; end
        endcase
        while (!rdy(kind) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL push_timeout: kind %0d never got ready", kind);
        end
        @(negedge clk);
        bus.filter_valid = 1'b0;
        bus.ifmap_valid  = 1'b0;
        bus.ipsum_valid  = 1'b0;
    endtask

    task automatic pop(input string name, input logic [31:0] exp);
        int t;
        t = 0;
        while (!bus.opsum_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: opsum_valid never rose", name);
        end
        check(name, bus.opsum, exp);
        bus.opsum_ready = 1'b1;
        @(negedge clk);
        bus.opsum_ready = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_hs"}, {28'd0, bus.filter_ready, bus.ifmap_ready, bus.ipsum_ready, bus.opsum_valid}, 32'd0);
        check({tag, "_state"}, 32'(dut.state_q), 32'd0);
    endtask

    task automatic run_std3x3(input string tag);
        int lat;
        start(mk_cfg(1'b0, 1'b0, 3, 1, 2, 1));
        push(0, 32'd1); push(0, 32'd2); push(0, 32'd3);
        push(1, ifw(8'h81)); push(1, ifw(8'h82)); push(1, ifw(8'h83));
        push(2, 32'd0);
        lat = 1;
        while (!bus.opsum_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd4);
        pop({tag, "_col0"}, 32'd14);
        push(1, ifw(8'h84));
        check({tag, "_col1_to_ipsum"}, 32'(bus.ipsum_ready), 32'd1);
        push(2, 32'd0);
        pop({tag, "_col1"}, 32'd20);
        push(1, ifw(8'h85));
        push(2, 32'd0);
        pop({tag, "_col2"}, 32'd26);
        check_idle(tag);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp;
        vecs[0] = '{8'h01, 8'h81, 32'h0000_0000, 32'h0000_0001, 32'h0000_0001};
        vecs[1] = '{8'hFF, 8'h81, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[2] = '{8'h80, 8'h00, 32'h0000_0000, 32'h0000_4000, 32'h0000_4000};
        vecs[3] = '{8'h7F, 8'hFF, 32'h7FFF_FFFF, 32'h8000_3F00, 32'h7FFF_FFFF};
        vecs[4] = '{8'h80, 8'hFF, 32'h8000_0000, 32'h7FFF_C080, 32'h8000_0000};
        vecs[5] = '{8'h05, 8'h7D, 32'h0000_0064, 32'h0000_0055, 32'h0000_0055};
        vecs[6] = '{8'h7F, 8'h80, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678};
        vecs[7] = '{8'h03, 8'h84, 32'hFFFF_FFF0, 32'hFFFF_FFFC, 32'hFFFF_FFFC};

        rst              = 1'b1;
        PE_en            = 1'b0;
        i_config         = 14'd0;
        bus.filter       = 32'd0;
        bus.ifmap        = 32'd0;
        bus.ipsum        = 32'd0;
        bus.filter_valid = 1'b0;
        bus.ifmap_valid  = 1'b0;
        bus.ipsum_valid  = 1'b0;
        bus.opsum_ready  = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        check("reset_opsum", bus.opsum, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single-MAC table: q=p=R=1, one column.
        for (int i = 0; i < 8; i++) begin
`ifdef PE_SATURATE_EN
            exp = vecs[i].exp_sat;
`else
            exp = vecs[i].exp_wrap;
`endif
            start(mk_cfg(1'b0, 1'b0, 1, 1, 0, 1));
            push(0, {24'd0, vecs[i].fb});
            push(1, ifw(vecs[i].ib));
            push(2, vecs[i].ip);
            pop($sformatf("mac_vec%0d", i), exp);
        end
        check_idle("mac_table");

        run_std3x3("std");

        // Stride 2, two output columns.
        start(mk_cfg(1'b1, 1'b0, 3, 1, 1, 1));
        push(0, 32'd1); push(0, 32'd2); push(0, 32'd3);
        push(1, ifw(8'h81)); push(1, ifw(8'h82)); push(1, ifw(8'h83));
        push(2, 32'd0);
        pop("s2_col0", 32'd14);
        push(1, ifw(8'h84));
        check("s2_after_1_beat", {30'd0, bus.ifmap_ready, bus.ipsum_ready}, 32'd2);
        push(1, ifw(8'h85));
        check("s2_after_2_beats", {30'd0, bus.ifmap_ready, bus.ipsum_ready}, 32'd1);
        push(2, 32'd0);
        pop("s2_col1", 32'd26);
        check_idle("s2");

        // Depthwise q=2, R=2, p field 3.
        start(mk_cfg(1'b0, 1'b1, 2, 4, 0, 2));
        push(0, 32'h0000_0101);
        push(0, 32'h0000_0101);
        check("dw_filter_beats", {30'd0, bus.filter_ready, bus.ifmap_ready}, 32'd1);
        push(1, 32'h8080_8281);
        push(1, 32'h8080_8483);
        push(2, 32'd10);
        push(2, 32'd20);
        pop("dw_op0", 32'd14);
        pop("dw_op1", 32'd26);
        check_idle("dw");

        // Backpressure with p=2: psum0 = 100+1*5+2*6, psum1 = 200+3*5+4*6.
        start(mk_cfg(1'b0, 1'b0, 2, 2, 0, 1));
        push(0, 32'd1); push(0, 32'd2); push(0, 32'd3); push(0, 32'd4);
        push(1, ifw(8'h85)); push(1, ifw(8'h86));
        push(2, 32'd100); push(2, 32'd200);
        for (int t = 0; t < 100 && !bus.opsum_valid; t++) @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp_valid_c%0d", c), 32'(bus.opsum_valid), 32'd1);
            check($sformatf("bp_opsum_c%0d", c), bus.opsum, 32'd117);
            check($sformatf("bp_idx_c%0d", c), 32'(dut.idx_q), 32'd0);
            @(negedge clk);
        end
        pop("bp_op0", 32'd117);
        pop("bp_op1", 32'd239);
        check_idle("bp");

        // Reset while in CONV, then a fresh complete run.
        start(mk_cfg(1'b0, 1'b0, 3, 1, 2, 1));
        push(0, 32'd1); push(0, 32'd2); push(0, 32'd3);
        push(1, ifw(8'h81)); push(1, ifw(8'h82)); push(1, ifw(8'h83));
        push(2, 32'd0);
        rst = 1'b1;
        #1;
        check_idle("rst_conv");
        check("rst_conv_opsum", bus.opsum, 32'd0);
        check("rst_conv_ptr", 32'(dut.ptr_q), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_std3x3("after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
